// File: rtl/ram_wrap_pkg.sv
// Shared types and helpers for the multi-port test memory: message structs,
// request type codes, byte-lane masking and the stall LFSR step.
package ram_wrap_pkg;

  localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;
  localparam logic [2:0] MEM_TYPE_INIT  = 3'd2;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  // Byte lanes covered by an access of len bytes (0 means 4) starting at off,
  // with anything past lane 3 dropped rather than wrapped.
  function automatic logic [3:0] byte_mask(input logic [1:0] len, input logic [1:0] off);
    logic [6:0] m;
    m = (len == 2'd0) ? 7'h0f : ((7'h01 << len) - 7'h01);
    m = m << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] bit_mask(input logic [3:0] bm);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{bm[b]}};
    return m;
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/ram_wrap_nport_pipe.sv
// Per-port response path: latency delay line, response FIFO, outstanding
// counter and stall LFSR that together produce req_rdy/resp_val.
module ram_port_pipe
  import ram_wrap_pkg::*;
#(
  parameter int unsigned P_LATENCY = 0,
  parameter int unsigned P_QDEPTH  = 2,
  parameter logic [15:0] P_SEED    = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_en,
  input  logic         req_val,
  input  mem_resp_4B_t rsp_in,
  output logic         req_rdy,
  output logic         resp_val,
  input  logic         resp_rdy,
  output mem_resp_4B_t resp_msg
);

  localparam int unsigned PW = (P_QDEPTH > 1) ? $clog2(P_QDEPTH) : 1;
  localparam int unsigned CW = $clog2(P_QDEPTH + 1);

  logic [15:0]   lfsr;
  logic [CW-1:0] outst, qcnt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          acc, pop, push;
  mem_resp_4B_t  push_msg;
  mem_resp_4B_t  fifo [P_QDEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(P_QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Outstanding count covers both the delay line and the FIFO, so the FIFO
  // can never be pushed while full.
  assign req_rdy  = rst && (outst < CW'(P_QDEPTH)) && !(stall_en && lfsr[0]);
  assign acc      = req_val && req_rdy;
  assign resp_val = (qcnt != '0);
  assign resp_msg = resp_val ? fifo[rd_ptr] : '0;
  assign pop      = resp_val && resp_rdy;

  if (P_LATENCY == 0) begin : g_nolat
    assign push     = acc;
    assign push_msg = rsp_in;
  end else begin : g_lat
    logic [P_LATENCY:1] vld_pipe;
    mem_resp_4B_t       msg_pipe [P_LATENCY:1];

    always_ff @(posedge clk) begin
      if (!rst) vld_pipe <= '0;
      else begin
        vld_pipe[1] <= acc;
        for (int s = 2; s <= P_LATENCY; s++) vld_pipe[s] <= vld_pipe[s-1];
      end
      msg_pipe[1] <= rsp_in;
      for (int s = 2; s <= P_LATENCY; s++) msg_pipe[s] <= msg_pipe[s-1];
    end

    assign push     = vld_pipe[P_LATENCY];
    assign push_msg = msg_pipe[P_LATENCY];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr   <= P_SEED;
      outst  <= '0;
      qcnt   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      lfsr  <= lfsr_next(lfsr);
      outst <= outst + CW'(acc) - CW'(pop);
      qcnt  <= qcnt + CW'(push) - CW'(pop);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= push_msg;
  end

endmodule

// File: rtl/ram_wrap_nport.sv
// N-port test memory over one shared word array; reads see pre-edge data,
// same-edge writes land in ascending port order.
module ram_wrap_nport
  import ram_wrap_pkg::*;
#(
  parameter int unsigned P_NUM_PORTS   = 2,
  parameter int unsigned P_DEPTH_WORDS = 4096,
  parameter int unsigned P_LATENCY     = 0,
  parameter int unsigned P_QDEPTH      = 2,
  parameter logic [15:0] P_LFSR_SEED   = 16'hACE1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            stall_en,
  input  mem_req_4B_t  [P_NUM_PORTS-1:0]  req_msg,
  input  logic         [P_NUM_PORTS-1:0]  req_val,
  output logic         [P_NUM_PORTS-1:0]  req_rdy,
  output mem_resp_4B_t [P_NUM_PORTS-1:0]  resp_msg,
  output logic         [P_NUM_PORTS-1:0]  resp_val,
  input  logic         [P_NUM_PORTS-1:0]  resp_rdy
);

  localparam int unsigned AW = $clog2(P_DEPTH_WORDS);

  logic [31:0] mem [P_DEPTH_WORDS];

  logic [P_NUM_PORTS-1:0]        wr_en;
  logic [P_NUM_PORTS-1:0][3:0]   wmask;
  logic [P_NUM_PORTS-1:0][31:0]  wdata;
  logic [AW-1:0]                 widx [P_NUM_PORTS];

  for (genvar p = 0; p < P_NUM_PORTS; p++) begin : g_port
    logic [1:0]   off;
    logic [31:0]  rword;
    mem_resp_4B_t rsp;

    // High address bits above the word index are ignored, so the array wraps.
    assign widx[p] = req_msg[p].addr[2 +: AW];
    assign off     = req_msg[p].addr[1:0];
    assign rword   = mem[widx[p]];

    always_comb begin
      rsp        = '0;
      rsp.typ    = req_msg[p].typ;
      rsp.opaque = req_msg[p].opaque;
      rsp.len    = req_msg[p].len;
      if (req_msg[p].typ == MEM_TYPE_READ)
        rsp.data = (rword >> {off, 3'b000}) & bit_mask(byte_mask(req_msg[p].len, 2'd0));
    end

    assign wr_en[p] = req_val[p] && req_rdy[p] &&
                      (req_msg[p].typ == MEM_TYPE_WRITE || req_msg[p].typ == MEM_TYPE_INIT);
    assign wmask[p] = byte_mask(req_msg[p].len, off);
    assign wdata[p] = req_msg[p].data << {off, 3'b000};

    ram_port_pipe #(
      .P_LATENCY (P_LATENCY),
      .P_QDEPTH  (P_QDEPTH),
      .P_SEED    (P_LFSR_SEED ^ 16'(p))
    ) u_pipe (
      .clk      (clk),
      .rst      (rst),
      .stall_en (stall_en),
      .req_val  (req_val[p]),
      .rsp_in   (rsp),
      .req_rdy  (req_rdy[p]),
      .resp_val (resp_val[p]),
      .resp_rdy (resp_rdy[p]),
      .resp_msg (resp_msg[p])
    );
  end

  // Later ports overwrite earlier ones on shared bytes.
  always_ff @(posedge clk) begin
    for (int p = 0; p < P_NUM_PORTS; p++)
      if (wr_en[p])
        for (int b = 0; b < 4; b++)
          if (wmask[p][b]) mem[widx[p]][8*b +: 8] <= wdata[p][8*b +: 8];
  end

endmodule

// File: tb/tb_ram_wrap_nport.sv
// Directed checks on a zero-latency instance, then random two-port traffic
// with stalls on a latency-3 instance against a byte-level reference memory.
module tb_ram_wrap_nport;
  import ram_wrap_pkg::*;

  logic clk, rst, stall0, stall3;
  mem_req_4B_t  [1:0] req0, req3;
  mem_resp_4B_t [1:0] resp0, resp3;
  logic [1:0] val0, rdy0, rv0, rr0, val3, rdy3, rv3, rr3;

  int total = 0;
  int bad   = 0;

  logic [31:0]  ref_mem [256];
  mem_resp_4B_t expq [2][$];

  ram_wrap_nport #(.P_NUM_PORTS(2), .P_DEPTH_WORDS(256), .P_LATENCY(0), .P_QDEPTH(2)) dut0 (
    .clk(clk), .rst(rst), .stall_en(stall0), .req_msg(req0), .req_val(val0), .req_rdy(rdy0),
    .resp_msg(resp0), .resp_val(rv0), .resp_rdy(rr0));

  ram_wrap_nport #(.P_NUM_PORTS(2), .P_DEPTH_WORDS(256), .P_LATENCY(3), .P_QDEPTH(2)) dut3 (
    .clk(clk), .rst(rst), .stall_en(stall3), .req_msg(req3), .req_val(val3), .req_rdy(rdy3),
    .resp_msg(resp3), .resp_val(rv3), .resp_rdy(rr3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic mem_req_4B_t mk(input logic [2:0] t, input logic [31:0] a,
                                     input logic [1:0] l, input logic [31:0] d,
                                     input logic [7:0] o);
    mem_req_4B_t r;
    r = '{typ: t, opaque: o, addr: a, len: l, data: d};
    return r;
  endfunction

  // Single transaction on dut0 port p; returns its response.
  task automatic d0_txn(input int p, input mem_req_4B_t rq, output mem_resp_4B_t r);
    int n;
    req0[p] = rq;
    val0[p] = 1'b1;
    #1;
    n = 0;
    while (!rdy0[p] && n < 20) begin @(posedge clk); #1; n++; end
    chk("txn_rdy", 64'(rdy0[p]), 64'd1);
    chk("txn_pre_val", 64'(rv0[p]), 64'd0);
    @(posedge clk); #1;
    val0[p] = 1'b0;
    chk("txn_lat", 64'(rv0[p]), 64'd1);
    r = resp0[p];
    @(posedge clk); #1;
  endtask

  // Both dut0 ports issue in the same cycle.
  task automatic d0_pair(input mem_req_4B_t a, input mem_req_4B_t b,
                         output mem_resp_4B_t ra, output mem_resp_4B_t rb);
    req0[0] = a;
    req0[1] = b;
    val0 = 2'b11;
    #1;
    chk("pair_rdy", 64'(rdy0), 64'd3);
    @(posedge clk); #1;
    val0 = 2'b00;
    chk("pair_val", 64'(rv0), 64'd3);
    ra = resp0[0];
    rb = resp0[1];
    @(posedge clk); #1;
  endtask

  // Reference behaviour computed byte by byte.
  function automatic mem_resp_4B_t model_rsp(input mem_req_4B_t r);
    mem_resp_4B_t e;
    int nb, off;
    logic [31:0] w;
    nb  = (r.len == 0) ? 4 : int'(r.len);
    off = int'(r.addr[1:0]);
    w   = ref_mem[r.addr[9:2]];
    e = '0;
    e.typ = r.typ; e.opaque = r.opaque; e.len = r.len;
    if (r.typ == 3'd0)
      for (int b = 0; b < nb; b++)
        if (off + b < 4) e.data[8*b +: 8] = w[8*(off+b) +: 8];
    return e;
  endfunction

  task automatic model_wr(input mem_req_4B_t r);
    int nb, off;
    if (r.typ == 3'd1 || r.typ == 3'd2) begin
      nb  = (r.len == 0) ? 4 : int'(r.len);
      off = int'(r.addr[1:0]);
      for (int b = 0; b < nb; b++)
        if (off + b < 4) ref_mem[r.addr[9:2]][8*(off+b) +: 8] = r.data[8*b +: 8];
    end
  endtask

  function automatic mem_req_4B_t rand_req();
    mem_req_4B_t r;
    int k;
    logic [31:0] a;
    k = $urandom_range(0, 9);
    a = ($urandom() & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    r.typ    = (k < 4) ? 3'd0 : (k < 7) ? 3'd1 : (k < 9) ? 3'd2 : 3'd5;
    r.opaque = 8'($urandom());
    r.addr   = a;
    r.len    = 2'($urandom_range(0, 3));
    r.data   = $urandom();
    return r;
  endfunction

  initial begin
    mem_resp_4B_t r, rb;
    mem_resp_4B_t e;
    logic [7:0]  got_o [$];
    logic [31:0] got_d [$];
    logic [1:0]  acc;
    int accepted, n;
    logic acc0;

    rst = 1'b0; stall0 = 1'b0; stall3 = 1'b0;
    req0 = '0; req3 = '0;
    val0 = 2'b01; val3 = 2'b11; rr0 = 2'b11; rr3 = 2'b11;

    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_rdy0", 64'(rdy0), 64'd0);
      chk("rst_val0", 64'(rv0), 64'd0);
      chk("rst_msg0", 64'(resp0[0]), 64'd0);
      chk("rst_rdy3", 64'(rdy3), 64'd0);
    end
    rst = 1'b1; val0 = 2'b00; val3 = 2'b00;
    @(posedge clk); #1;
    chk("rel_rdy0", 64'(rdy0), 64'd3);
    chk("rel_val0", 64'(rv0), 64'd0);

    // full word write, read back, sub-word write and truncated read
    d0_txn(0, mk(MEM_TYPE_WRITE, 32'h10, 2'd0, 32'hDEADBEEF, 8'h11), r);
    chk("wr_data", 64'(r.data), 64'd0);
    chk("wr_typ", 64'(r.typ), 64'd1);
    chk("wr_opq", 64'(r.opaque), 64'h11);
    d0_txn(0, mk(MEM_TYPE_READ, 32'h10, 2'd0, 32'h0, 8'h42), r);
    chk("rd_data", 64'(r.data), 64'hDEADBEEF);
    chk("rd_typ", 64'(r.typ), 64'd0);
    chk("rd_opq", 64'(r.opaque), 64'h42);
    chk("rd_test", 64'(r.test), 64'd0);
    d0_txn(0, mk(MEM_TYPE_WRITE, 32'h11, 2'd1, 32'h55, 8'h12), r);
    d0_txn(0, mk(MEM_TYPE_READ, 32'h10, 2'd0, 32'h0, 8'h13), r);
    chk("sub_rd", 64'(r.data), 64'hDEAD55EF);
    d0_txn(0, mk(MEM_TYPE_READ, 32'h13, 2'd2, 32'h0, 8'h14), r);
    chk("trunc_rd", 64'(r.data), 64'hDE);
    chk("trunc_len", 64'(r.len), 64'd2);

    // backpressure: queue depth 2 with the response side stalled
    d0_txn(0, mk(MEM_TYPE_INIT, 32'h14, 2'd0, 32'hA5A5A5A5, 8'h0), r);
    d0_txn(0, mk(MEM_TYPE_WRITE, 32'h18, 2'd0, 32'h5A5A5A5A, 8'h0), r);
    rr0[0] = 1'b0;
    req0[0] = mk(MEM_TYPE_READ, 32'h10, 2'd0, 32'h0, 8'd1);
    val0[0] = 1'b1;
    #1; chk("bp_rdy1", 64'(rdy0[0]), 64'd1);
    @(posedge clk); #1;
    req0[0] = mk(MEM_TYPE_READ, 32'h14, 2'd0, 32'h0, 8'd2);
    #1; chk("bp_rdy2", 64'(rdy0[0]), 64'd1);
    @(posedge clk); #1;
    req0[0] = mk(MEM_TYPE_READ, 32'h18, 2'd0, 32'h0, 8'd3);
    #1; chk("bp_full", 64'(rdy0[0]), 64'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_hold_rdy", 64'(rdy0[0]), 64'd0);
    chk("bp_hold_val", 64'(rv0[0]), 64'd1);
    chk("bp_hold_opq", 64'(resp0[0].opaque), 64'd1);
    rr0[0] = 1'b1;
    for (int c = 0; c < 12 && got_o.size() < 3; c++) begin
      if (rv0[0]) begin got_o.push_back(resp0[0].opaque); got_d.push_back(resp0[0].data); end
      acc0 = val0[0] && rdy0[0];
      @(posedge clk); #1;
      if (acc0) val0[0] = 1'b0;
    end
    chk("bp_count", 64'(got_o.size()), 64'd3);
    if (got_o.size() == 3) begin
      chk("bp_o1", 64'(got_o[0]), 64'd1); chk("bp_d1", 64'(got_d[0]), 64'hDEAD55EF);
      chk("bp_o2", 64'(got_o[1]), 64'd2); chk("bp_d2", 64'(got_d[1]), 64'hA5A5A5A5);
      chk("bp_o3", 64'(got_o[2]), 64'd3); chk("bp_d3", 64'(got_d[2]), 64'h5A5A5A5A);
    end
    val0[0] = 1'b0;
    @(posedge clk); #1;

    // same-cycle multi-port ordering and wrap-around aliasing
    d0_pair(mk(MEM_TYPE_WRITE, 32'h20, 2'd0, 32'h1111, 8'h1),
            mk(MEM_TYPE_WRITE, 32'h20, 2'd0, 32'h2222, 8'h2), r, rb);
    d0_pair(mk(MEM_TYPE_READ, 32'h20, 2'd0, 32'h0, 8'h3),
            mk(MEM_TYPE_WRITE, 32'h20, 2'd0, 32'h3333, 8'h4), r, rb);
    chk("mp_old", 64'(r.data), 64'h2222);
    d0_pair(mk(MEM_TYPE_READ, 32'h20, 2'd0, 32'h0, 8'h5),
            mk(MEM_TYPE_READ, 32'h420, 2'd0, 32'h0, 8'h6), r, rb);
    chk("mp_new", 64'(r.data), 64'h3333);
    chk("wrap_rd", 64'(rb.data), 64'h3333);
    d0_txn(1, mk(3'd5, 32'h20, 2'd0, 32'hFFFF, 8'h7), r);
    chk("oth_data", 64'(r.data), 64'd0);
    chk("oth_typ", 64'(r.typ), 64'd5);
    d0_txn(0, mk(MEM_TYPE_READ, 32'h20, 2'd0, 32'h0, 8'h8), r);
    chk("oth_noeff", 64'(r.data), 64'h3333);

    // preload dut3 words 0..15 so the random phase never reads unknowns
    for (int w = 0; w < 16; w++) begin
      ref_mem[w] = $urandom();
      req3[0] = mk(MEM_TYPE_INIT, 32'(w) << 2, 2'd0, ref_mem[w], 8'h0);
      val3[0] = 1'b1;
      #1;
      n = 0;
      while (!rdy3[0] && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      val3[0] = 1'b0;
    end
    repeat (10) begin @(posedge clk); #1; end
    chk("pre_drained", 64'(rv3), 64'd0);

    // random two-port traffic with stall injection
    stall3 = 1'b1;
    accepted = 0;
    for (int p = 0; p < 2; p++) begin req3[p] = rand_req(); val3[p] = 1'b1; end
    #1;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (accepted >= 200 && val3 == 2'b00 && expq[0].size() == 0 && expq[1].size() == 0) break;
      for (int p = 0; p < 2; p++)
        if (rv3[p] && rr3[p]) begin
          if (expq[p].size() == 0) chk("rnd_spurious", 64'd1, 64'd0);
          else begin
            e = expq[p].pop_front();
            chk("rnd_data", 64'(resp3[p].data), 64'(e.data));
            chk("rnd_meta", 64'({resp3[p].typ, resp3[p].opaque, resp3[p].test, resp3[p].len}),
                64'({e.typ, e.opaque, e.test, e.len}));
          end
        end
      acc = val3 & rdy3;
      for (int p = 0; p < 2; p++) if (acc[p]) expq[p].push_back(model_rsp(req3[p]));
      for (int p = 0; p < 2; p++) if (acc[p]) model_wr(req3[p]);
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++)
        if (acc[p]) begin
          accepted++;
          val3[p] = 1'b0;
          if (accepted < 200 && $urandom_range(0, 3) != 0) begin
            req3[p] = rand_req(); val3[p] = 1'b1;
          end
        end else if (!val3[p] && accepted < 200) begin
          req3[p] = rand_req(); val3[p] = 1'b1;
        end
      rr3 = 2'($urandom_range(0, 3)) | 2'($urandom_range(0, 3));
      #1;
    end
    chk("rnd_accepted", 64'(accepted >= 200), 64'd1);
    chk("rnd_q0_empty", 64'(expq[0].size()), 64'd0);
    chk("rnd_q1_empty", 64'(expq[1].size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
